// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: turns field bundles into machine words at sequential
// word addresses for loading instruction RAM, one session of `count` words per start.
module rv_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       kind,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             busy,
  output logic             done,
  output logic             err_illegal,
  output logic             err_range
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting bundles, remaining counts down to zero
  // DRAIN | all bundles taken, waiting for the last word to leave
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  localparam logic [3:0] kAluReg = 4'd0, kAluImm = 4'd1, kBranch = 4'd2, kJalr = 4'd3,
                         kJal = 4'd4, kAuipc = 4'd5, kLui = 4'd6, kLoad = 4'd7,
                         kStore = 4'd8, kSystem = 4'd9;

  stateT            state;
  logic [31:0]      addrReg;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      encWord;
  logic             encRange;
  logic             encIllegal;
  logic             iOk, bOk, jOk, uOk;
  logic             accept;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Sign-extension checks: the dropped high bits must all equal the kept sign bit.
  assign iOk = (&imm[31:11]) || !(|imm[31:11]);
  assign bOk = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
  assign jOk = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
  assign uOk = !(|imm[11:0]);

  always_comb begin
    encWord    = 32'h0000_0013;
    encRange   = 1'b0;
    encIllegal = 1'b0;
    case (kind)
      kAluReg: encWord = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      kAluImm: begin encWord = {imm[11:0], rs1, funct3, rd, 7'b0010011}; encRange = !iOk; end
      kLoad:   begin encWord = {imm[11:0], rs1, funct3, rd, 7'b0000011}; encRange = !iOk; end
      kSystem: begin encWord = {imm[11:0], rs1, funct3, rd, 7'b1110011}; encRange = !iOk; end
      kJalr:   begin encWord = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; encRange = !iOk; end
      kStore: begin
        encWord  = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        encRange = !iOk;
      end
      kBranch: begin
        encWord  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        encRange = !bOk;
      end
      kJal: begin
        encWord  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        encRange = !jOk;
      end
      kLui:    begin encWord = {imm[31:12], rd, 7'b0110111}; encRange = !uOk; end
      kAuipc:  begin encWord = {imm[31:12], rd, 7'b0010111}; encRange = !uOk; end
      default: encIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addrReg     <= '0;
      remaining   <= '0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
            if (count != '0) begin
              state     <= RUN;
              busy      <= 1'b1;
              addrReg   <= {base_addr[31:2], 2'b00};
              remaining <= count;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= encWord;
            out_addr  <= addrReg;
            addrReg   <= addrReg + 32'd4;
            remaining <= remaining - CNT_W'(1);
            if (encRange)   err_range   <= 1'b1;
            if (encIllegal) err_illegal <= 1'b1;
            if (remaining == CNT_W'(1)) state <= DRAIN;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: hand-encoded instruction vectors,
// backpressure, error flags, edge counts, address wrap and mid-session reset.
module tb_rv_instr_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       kind;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_addr;
  logic             busy;
  logic             done;
  logic             err_illegal;
  logic             err_range;

  rv_instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  vKind[16];
  logic [4:0]  vRd[16], vRs1[16], vRs2[16];
  logic [2:0]  vF3[16];
  logic [6:0]  vF7[16];
  logic [31:0] vImm[16], vExp[16];
  logic [31:0] gotInstr[16], gotAddr[16];
  int          gotN, doneCnt, viol;
  logic        timedOut, busyAfterStart, busyAtDone, validAtDone;

  task automatic setVec(input int i, input logic [3:0] k, input logic [4:0] rdI,
                        input logic [4:0] rs1I, input logic [4:0] rs2I, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input logic [31:0] ex);
    vKind[i] = k; vRd[i] = rdI; vRs1[i] = rs1I; vRs2[i] = rs2I;
    vF3[i] = f3; vF7[i] = f7; vImm[i] = im; vExp[i] = ex;
  endtask

  task automatic driveBundle(input int i);
    kind = vKind[i]; rd = vRd[i]; rs1 = vRs1[i]; rs2 = vRs2[i];
    funct3 = vF3[i]; funct7 = vF7[i]; imm = vImm[i];
  endtask

  // Runs one session; bpMode 1 drives out_ready as 1,0,0,1 repeating.
  task automatic driveSession(input logic [31:0] base, input int n, input int bpMode,
                              input int midStartCyc);
    int idx, doneAt;
    logic prevStall;
    logic [31:0] prevI, prevA;
    gotN = 0; doneCnt = 0; viol = 0; idx = 0; doneAt = -1; prevStall = 1'b0;
    prevI = '0; prevA = '0; busyAtDone = 1'bx; validAtDone = 1'bx;
    for (int i = 0; i < 16; i++) begin gotInstr[i] = 'x; gotAddr[i] = 'x; end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = CNT_W'(n); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busyAfterStart = busy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCnt == 1) begin busyAtDone = busy; validAtDone = out_valid; doneAt = cyc; end
      end
      if (doneAt >= 0 && cyc >= doneAt + 2) break;
      if (prevStall && (out_valid !== 1'b1 || out_instr !== prevI || out_addr !== prevA)) viol++;
      if (cyc == midStartCyc) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; count = CNT_W'(7);
      end else begin
        start = 1'b0;
      end
      out_ready = (bpMode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid = (idx < n);
      if (idx < n) driveBundle(idx);
      #1;
      if (out_valid && !out_ready && in_ready) viol++;
      if (out_valid && out_ready) begin
        if (gotN < 16) begin gotInstr[gotN] = out_instr; gotAddr[gotN] = out_addr; end
        gotN++;
      end
      if (in_valid && in_ready) idx++;
      prevStall = out_valid && !out_ready;
      prevI = out_instr;
      prevA = out_addr;
      @(posedge clk); #1;
    end
    timedOut = (doneAt < 0);
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    kind = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err_illegal, err_range} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {in_ready, out_valid, busy, done, err_illegal, err_range});
    end
    checks++;
    if (out_instr !== 32'h0 || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got instr %h addr %h expected 0 0", out_instr, out_addr);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy, done} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b expected 000", {in_ready, busy, done});
    end
  endtask

  task automatic checkWords(input string name, input int n, input logic [31:0] base);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("FAIL %s_timeout got no done", name); end
    checks++;
    if (gotN !== n) begin errors++; $display("FAIL %s_count got %0d expected %0d", name, gotN, n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gotInstr[i] !== vExp[i]) begin
        errors++;
        $display("FAIL %s_instr[%0d] got %h expected %h", name, i, gotInstr[i], vExp[i]);
      end
      checks++;
      if (gotAddr[i] !== base + 32'(4 * i)) begin
        errors++;
        $display("FAIL %s_addr[%0d] got %h expected %h", name, i, gotAddr[i], base + 32'(4 * i));
      end
    end
    checks++;
    if (doneCnt !== 1) begin errors++; $display("FAIL %s_done_pulses got %0d expected 1", name, doneCnt); end
    checks++;
    if ({busyAfterStart, busyAtDone, validAtDone} !== 3'b100) begin
      errors++;
      $display("FAIL %s_busy got start/done/valid %b expected 100", name,
               {busyAfterStart, busyAtDone, validAtDone});
    end
  endtask

  task automatic test_basic;
    setVec(0, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093);
    setVec(1, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         32'h0020_81B3);
    setVec(2, 4'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463);
    setVec(3, 4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F);
    setVec(4, 4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7);
    setVec(5, 4'd8, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4,         32'h0020_A223);
    driveSession(32'h100, 6, 0, -1);
    checkWords("basic", 6, 32'h100);
    checks++;
    if ({err_illegal, err_range} !== 2'b00) begin
      errors++; $display("FAIL basic_errflags got %b expected 00", {err_illegal, err_range});
    end
  endtask

  task automatic test_backpressure;
    setVec(0, 4'd3, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd16,        32'h0101_00E7);
    setVec(1, 4'd7, 5'd4, 5'd3, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFF81_A203);
    setVec(2, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0073);
    setVec(3, 4'd2, 5'd0, 5'd1, 5'd2, 3'd4, 7'd0, 32'hFFFF_FFF0, 32'hFE20_C8E3);
    driveSession(32'h1002, 4, 1, -1);
    checkWords("bp", 4, 32'h1000);
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL bp_stall_violations got %0d expected 0", viol); end
    checks++;
    if ({err_illegal, err_range} !== 2'b00) begin
      errors++; $display("FAIL bp_errflags got %b expected 00", {err_illegal, err_range});
    end
  endtask

  task automatic test_errors;
    setVec(0, 4'd1,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093);
    setVec(1, 4'd12, 5'd7, 5'd3, 5'd4, 3'd5, 7'd1, 32'd9,    32'h0000_0013);
    setVec(2, 4'd0,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,    32'h0020_81B3);
    driveSession(32'h200, 3, 0, -1);
    checkWords("err", 3, 32'h200);
    checks++;
    if (err_range !== 1'b1) begin errors++; $display("FAIL err_range got %b expected 1", err_range); end
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++; $display("FAIL err_illegal got %b expected 1", err_illegal);
    end
  endtask

  task automatic test_count_zero;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h40; count = '0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({done, busy, out_valid, err_illegal, err_range} !== 5'b10000) begin
      errors++;
      $display("FAIL zero_first got done/busy/valid/ill/rng %b expected 10000",
               {done, busy, out_valid, err_illegal, err_range});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, out_valid} !== 3'b000) begin
      errors++; $display("FAIL zero_after got done/busy/valid %b expected 000", {done, busy, out_valid});
    end
  endtask

  task automatic test_wrap;
    setVec(0, 4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7);
    setVec(1, 4'd5, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1317);
    driveSession(32'hFFFF_FFFC, 2, 0, -1);
    checks++;
    if (gotN !== 2 || gotInstr[0] !== vExp[0] || gotInstr[1] !== vExp[1]) begin
      errors++;
      $display("FAIL wrap_words got n=%0d %h %h expected n=2 %h %h",
               gotN, gotInstr[0], gotInstr[1], vExp[0], vExp[1]);
    end
    checks++;
    if (gotAddr[0] !== 32'hFFFF_FFFC || gotAddr[1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr got %h %h expected fffffffc 00000000", gotAddr[0], gotAddr[1]);
    end
    checks++;
    if (doneCnt !== 1 || {err_illegal, err_range} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_done_flags got done=%0d flags=%b expected 1 00",
               doneCnt, {err_illegal, err_range});
    end
  endtask

  task automatic test_ignored_start;
    setVec(0, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    setVec(1, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3);
    setVec(2, 4'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463);
    setVec(3, 4'd8, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 32'h0020_A223);
    driveSession(32'h400, 4, 0, 1);
    checkWords("ignstart", 4, 32'h400);
  endtask

  task automatic test_reset_mid;
    int accepted;
    int sawDone;
    setVec(0, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093);
    setVec(1, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3);
    accepted = 0;
    sawDone = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h300; count = CNT_W'(5); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && accepted < 2; cyc++) begin
      in_valid = 1'b1;
      driveBundle(accepted);
      #1;
      if (in_ready) accepted++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h304) begin
      errors++;
      $display("FAIL rstmid_pre got valid=%b addr=%h expected 1 00000304", out_valid, out_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err_illegal, err_range} !== 6'b0 ||
        out_instr !== 32'h0 || out_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got flags=%b instr=%h addr=%h expected 0",
               {in_ready, out_valid, busy, done, err_illegal, err_range}, out_instr, out_addr);
    end
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) sawDone++; end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) sawDone++; end
    checks++;
    if (sawDone !== 0) begin
      errors++; $display("FAIL rstmid_nodone got %0d done/busy cycles expected 0", sawDone);
    end
    driveSession(32'h500, 2, 0, -1);
    checkWords("rstmid_new", 2, 32'h500);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_count_zero();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Streaming RV32I instruction encoder that converts field-level instruction descriptions (class, register IDs, funct3/funct7, 32-bit immediate) into 32-bit machine words with target addresses. It is the inverse of the core's instruction decoder and sits between the test/boot sequencer and the instruction-memory write port. It is used to load programs into instruction RAM at run time. Each load is a session of `count` words written at sequential word addresses from `base_addr`.

## Interface
Parameters:
- `CNT_W`, default 16: width of the session word count.

Ports:
- `clk`: in, 1. Clock.
- `reset`: in, 1. Asynchronous, active-high reset.
- `start`: in, 1. Session start pulse. Sampled only in IDLE.
- `base_addr`: in, 32. First word address. Bits [1:0] are forced to 0.
- `count`: in, CNT_W. Number of words in the session.
- `in_valid`: in, 1. Field bundle valid.
- `in_ready`: out, 1. Encoder accepts the bundle.
- `kind`: in, 4. Instruction class:
  - 0 ALUreg, 1 ALUimm, 2 Branch, 3 JALR, 4 JAL
  - 5 AUIPC, 6 LUI, 7 Load, 8 Store, 9 SYSTEM
  - 10–15 illegal
- `rd`, `rs1`, `rs2`: in, 5 each. Register IDs.
- `funct3`: in, 3.
- `funct7`: in, 7.
- `imm`: in, 32. Signed immediate. For U-type it is the full 32-bit value.
- `out_valid`: out, 1. Encoded word valid.
- `out_ready`: in, 1. Memory port accepts the word.
- `out_instr`: out, 32. Encoded instruction.
- `out_addr`: out, 32. Target byte address.
- `busy`: out, 1. High in RUN or DRAIN.
- `done`: out, 1. One-cycle pulse at session end.
- `err_illegal`: out, 1. Sticky. Cleared on an accepted `start`.
- `err_range`: out, 1. Sticky. Cleared on an accepted `start`.

## Operation
State machine:
- **IDLE**
  - `start` with `count`≠0: go to RUN. Load address register with `base_addr & ~3`, load remaining with `count`, clear both error flags.
  - `start` with `count`=0: clear flags, go to DONE.
- **RUN**
  - Each handshake (`in_valid & in_ready`) captures the encoded word into the output register with the current address.
  - Each handshake adds 4 to the address (wraps modulo 2^32) and decrements remaining.
  - When remaining reaches 0, go to DRAIN.
- **DRAIN**: when the output register is empty or is being emptied this cycle, go to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE.

`start` outside IDLE is ignored.

`in_ready` = (state==RUN) & (!`out_valid` | `out_ready`).

Encoding (opcode in bits [6:0]):
- ALUreg: {funct7, rs2, rs1, funct3, rd, 0110011}.
- ALUimm / Load / SYSTEM: {imm[11:0], rs1, funct3, rd, op}. op = 0010011 / 0000011 / 1110011.
- JALR: {imm[11:0], rs1, 000, rd, 1100111}. funct3 is forced to 000.
- Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
- Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
- LUI / AUIPC: {imm[31:12], rd, op}. op = 0110111 / 0010111.

Error rules (evaluated on the accepted bundle):
- `err_range` sets, and the word is still emitted with truncated fields, when:
  - I-type or S-type: imm[31:11] not all equal.
  - Branch: imm[31:12] not all equal, or imm[0]=1.
  - JAL: imm[31:20] not all equal, or imm[0]=1.
  - U-type: imm[11:0]≠0.
- Illegal `kind`:
  - Emits NOP 0x00000013 at the slot's address.
  - Consumes a count slot.
  - Sets `err_illegal`.
- Both flags may set in the same session. Neither flag aborts the session.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `done`=0.
  - `out_instr`=0, `out_addr`=0.
  - `err_illegal`=0, `err_range`=0.
  - Internal counters 0.
- Reset mid-session abandons the session immediately. No `done` pulse is produced.
- Latency: a bundle accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 word per cycle while `out_ready`=1.
- Backpressure: `out_valid` and `out_instr`/`out_addr` are held stable while `out_ready`=0.
- Simultaneous input accept and output drain in the same cycle are both honoured.
- `done` rises the cycle after the last output handshake.
- `count`=0 session: `done` is asserted the cycle after `start`, `busy` never rises.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises.

## Test plan
- **Basic encodings.** base 0x100, count 6. Expected words and addresses:
  - ADDI x1,x0,5 → 0x00500093 @0x100.
  - ADD x3,x1,x2 → 0x002081B3 @0x104.
  - BEQ x1,x2,+8 → 0x00208463 @0x108.
  - JAL x0,−4 → 0xFFDFF06F @0x10C.
  - LUI x5,0x12345000 → 0x123452B7 @0x110.
  - SW x2,4(x1) → 0x0020A223 @0x114.
  - Then `done` pulses once, and both error flags read 0.
- **Backpressure.** count 4, `out_ready` toggles 1,0,0,1,…
  - Every word appears exactly once, in order.
  - Outputs stay stable while stalled.
  - `in_ready` is 0 whenever `out_valid`=1 and `out_ready`=0.
- **Range and illegal errors.**
  - ADDI with imm=2048 → 0x80000093 and `err_range`=1.
  - kind=12 → 0x00000013 and `err_illegal`=1.
  - The next `start` clears both flags.
- **Edge counts and address wrap.**
  - count=0 → `done` the cycle after `start`, no `out_valid`.
  - base 0xFFFFFFFC, count 2 → addresses 0xFFFFFFFC then 0x00000000.
- **Reset mid-session.** Assert `reset` after 2 of 5 words with `out_valid`=1.
  - All outputs return to reset values.
  - No `done` pulse.
  - A new session then starts cleanly.
- **Ignored start.** `start` pulsed during RUN with a different `base_addr` → addresses continue unchanged.
